pio_in_debounce: RTL and testbench

- Parametrised Avalon-MM memory-mapped input PIO for pushbuttons and switches.
- Generalises the existing fixed 4-bit pushbutton PIO:
  - configurable width
  - 2-flop synchroniser
  - per-channel counter debounce
  - per-channel rising/falling edge selection
  - write-1-to-clear edge capture
  - selectable level or edge interrupt
- Sits on the system interconnect beside the other PIOs; drives one IRQ line to the CPU.

---
 rtl/pio_in_debounce.sv | 144 ++++++++++++++
 tb/tb_pio_in_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_debounce.sv
// Avalon-MM input PIO: synchroniser, per-channel debounce, edge capture, IRQ.
// Define PIO_IN_BITSET_EN to enable IRQ_MASK set/clear aliases at words 6/7.
module pio_in_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10,
  parameter int IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int DMAX =
    (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DMAX - 1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] debp_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] ec_q;
  logic [WIDTH-1:0] ec_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_hit;
  logic             wr;
  logic [31:0]      rd_d;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST)
          deb_d[i] = s2_q[i];
        else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign edge_hit = (deb_q & ~debp_q & rise_q)
                  | (~deb_q & debp_q & fall_q);

  always_comb begin
    mask_d = mask_q;
    rise_d = rise_q;
    fall_d = fall_q;
    clr    = '0;
    if (wr) begin
      case (address)
        3'd2: mask_d = wd;
        3'd3: clr    = wd;
        3'd4: rise_d = wd;
        3'd5: fall_d = wd;
`ifdef PIO_IN_BITSET_EN
        3'd6: mask_d = mask_q | wd;
        3'd7: mask_d = mask_q & ~wd;
`endif
        default: ;
      endcase
    end
    // a new edge outranks a simultaneous clear
    ec_d = (ec_q & ~clr) | edge_hit;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      3'd0: rd_d = 32'(deb_q);
      3'd1: rd_d = 32'(s2_q);
      3'd2: rd_d = 32'(mask_q);
      3'd3: rd_d = 32'(ec_q);
      3'd4: rd_d = 32'(rise_q);
      3'd5: rd_d = 32'(fall_q);
`ifdef PIO_IN_BITSET_EN
      3'd6: rd_d = 32'(mask_q);
      3'd7: rd_d = 32'(mask_q);
`endif
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      debp_q   <= '0;
      mask_q   <= '0;
      ec_q     <= '0;
      rise_q   <= '1;
      fall_q   <= '0;
      readdata <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= '0;
    end else begin
      s1_q     <= in_port;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      debp_q   <= deb_q;
      mask_q   <= mask_d;
      ec_q     <= ec_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      readdata <= rd_d;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  generate
    if (IRQ_MODE == 0) begin : g_level
      assign irq = |(deb_q & mask_q);
    end else begin : g_edge
      assign irq = |(ec_q & mask_q);
    end
  endgenerate

endmodule

// File: tb/tb_pio_in_debounce.sv
// Bench for pio_in_debounce: directed stimulus, history-based model,
// per-cycle compare of readdata and irq.
module tb_pio_in_debounce;

  localparam int D = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int tests;
  int fails;

  pio_in_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4),
    .IRQ_MODE(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: deb flips once the last D synchronised samples all disagree
  bit [3:0]  m_s1, m_s2, m_deb, m_debp;
  bit [3:0]  m_mask, m_ec, m_rise, m_fall;
  bit [3:0]  hist[$];
  bit [31:0] m_rd;
  bit        m_irq;
  bit [3:0]  e_v, clr_v, nd_v;
  bit        wr_v, all_v;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_debp = 0;
      m_mask = 0; m_ec = 0; m_rise = 4'hF; m_fall = 0;
      m_rd = 0; m_irq = 0;
      hist = {};
      for (int k = 0; k < D; k++) hist.push_back(4'h0);
    end else begin
      wr_v = chipselect && !write_n;
      case (address)
        3'd0: m_rd = 32'(m_deb);
        3'd1: m_rd = 32'(m_s2);
        3'd2: m_rd = 32'(m_mask);
        3'd3: m_rd = 32'(m_ec);
        3'd4: m_rd = 32'(m_rise);
        3'd5: m_rd = 32'(m_fall);
`ifdef PIO_IN_BITSET_EN
        3'd6: m_rd = 32'(m_mask);
        3'd7: m_rd = 32'(m_mask);
`endif
        default: m_rd = 0;
      endcase
      e_v = (m_deb & ~m_debp & m_rise) | (~m_deb & m_debp & m_fall);
      clr_v = (wr_v && address == 3'd3) ? writedata[3:0] : 4'h0;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      nd_v = m_deb;
      for (int i = 0; i < 4; i++) begin
        all_v = 1;
        for (int j = 0; j < D; j++)
          if (hist[j][i] == m_deb[i]) all_v = 0;
        if (all_v) nd_v[i] = ~m_deb[i];
      end
      if (wr_v) begin
        case (address)
          3'd2: m_mask = writedata[3:0];
          3'd4: m_rise = writedata[3:0];
          3'd5: m_fall = writedata[3:0];
`ifdef PIO_IN_BITSET_EN
          3'd6: m_mask = m_mask | writedata[3:0];
          3'd7: m_mask = m_mask & ~writedata[3:0];
`endif
          default: ;
        endcase
      end
      m_ec   = (m_ec & ~clr_v) | e_v;
      m_debp = m_deb;
      m_deb  = nd_v;
      m_s2   = m_s1;
      m_s1   = in_port;
      m_irq  = |(m_ec & m_mask);
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      chk("cyc_rd", readdata, m_rd);
      chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic bus_wr(logic [2:0] a, logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 0;
  endtask

  task automatic bus_rd(string n, logic [2:0] a, logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1 chk(n, readdata, exp);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; address = 0; chipselect = 0;
    write_n = 1'b1; writedata = 0; in_port = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", readdata, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    @(negedge clk) reset_n = 1'b1;

    bus_rd("rst_data", 3'd0, 0);
    bus_rd("rst_raw",  3'd1, 0);
    bus_rd("rst_mask", 3'd2, 0);
    bus_rd("rst_ec",   3'd3, 0);
    bus_rd("rst_rise", 3'd4, 32'hF);
    bus_rd("rst_fall", 3'd5, 0);

    bus_wr(3'd2, 32'h1);
    @(negedge clk);
    address = 3'd0; in_port = 4'b0001;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("data_k5", readdata, 0);
    chk("irq_k5", {31'b0, irq}, 0);
    @(posedge clk);
    #1;
    chk("data_k6", readdata, 32'h1);
    chk("irq_k6", {31'b0, irq}, 1);
    bus_wr(3'd3, 32'h1);
    chk("irq_clr", {31'b0, irq}, 0);

    @(negedge clk) in_port = 4'b0011;
    cyc(3);
    in_port = 4'b0001;
    cyc(12);
    bus_rd("glitch_data", 3'd0, 32'h1);
    bus_rd("glitch_ec", 3'd3, 0);
    chk("glitch_irq", {31'b0, irq}, 0);

    bus_wr(3'd4, 32'h0);
    bus_wr(3'd5, 32'h2);
    in_port = 4'b0011;
    cyc(12);
    bus_rd("norise_ec", 3'd3, 0);
    in_port = 4'b0001;
    cyc(12);
    bus_rd("fall_ec", 3'd3, 32'h2);
    in_port = 4'b0101;
    cyc(12);
    bus_rd("rise_off_ec", 3'd3, 32'h2);
    bus_wr(3'd3, 32'hF);
    bus_rd("clr_all_ec", 3'd3, 0);

    bus_wr(3'd4, 32'h1);
    in_port = 4'b0100;
    cyc(12);
    bus_rd("fall_off_ec", 3'd3, 0);
    @(negedge clk) in_port = 4'b0101;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 0;
    bus_rd("setwins_ec", 3'd3, 32'h1);
    chk("setwins_irq", {31'b0, irq}, 1);

    bus_wr(3'd2, 32'h5);
    bus_wr(3'd6, 32'h2);
`ifdef PIO_IN_BITSET_EN
    bus_rd("mask_set", 3'd2, 32'h7);
`else
    bus_rd("mask_set", 3'd2, 32'h5);
`endif
    bus_wr(3'd7, 32'h4);
`ifdef PIO_IN_BITSET_EN
    bus_rd("mask_clr", 3'd2, 32'h3);
    bus_rd("rd6", 3'd6, 32'h3);
    bus_rd("rd7", 3'd7, 32'h3);
`else
    bus_rd("mask_clr", 3'd2, 32'h5);
    bus_rd("rd6", 3'd6, 0);
    bus_rd("rd7", 3'd7, 0);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
